sfp_link_sequencer: RTL and testbench

Bring-up and recovery sequencer for the SFP+ USXGMII NBase-T port. It debounces SFP module presence and monitors LOS and TX_FAULT. It drives the SFP TX_DISABLE pin and the PHY/transceiver-reset-controller reset, then waits for transceiver ready and 64b/66b block lock, retrying with a bounded count. It sits beside the PHY control top level in the `i_clock` (CSR/reconfig) domain and replaces the direct `~(los|tx_fault|prsnt_n)` reset derivation.

---
 rtl/sfp_link_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sfp_link_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_link_sequencer.sv
// SFP+ bring-up/recovery sequencer: debounces presence, sequences TX_DISABLE and PHY reset,
// waits for transceiver ready and block lock, and retries a bounded number of times.
module sfp_link_sequencer #(
  parameter int p_DEBOUNCE_CYCLES = 1024,
  parameter int p_RESET_CYCLES    = 256,
  parameter int p_READY_TIMEOUT   = 1048576,
  parameter int p_LOCK_TIMEOUT    = 1048576,
  parameter int p_MAX_RETRIES     = 3
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_sfp_los,
  input  logic       i_sfp_tx_fault,
  input  logic       i_sfp_mod0_prsnt_n,
  input  logic       i_tx_ready,
  input  logic       i_rx_ready,
  input  logic       i_rx_block_lock,
  output logic       o_sfp_tx_disable,
  output logic       o_phy_reset,
  output logic       o_link_up,
  output logic       o_fault,
  output logic [2:0] o_state,
  output logic [3:0] o_retry_count
);

  localparam int TMAX_A = (p_RESET_CYCLES > p_READY_TIMEOUT) ? p_RESET_CYCLES : p_READY_TIMEOUT;
  localparam int TMAX   = (TMAX_A > p_LOCK_TIMEOUT) ? TMAX_A : p_LOCK_TIMEOUT;
  localparam int TW     = $clog2(TMAX) + 1;
  localparam int DW     = $clog2(p_DEBOUNCE_CYCLES + 1);

  localparam logic [TW-1:0] RESET_LAST = TW'(p_RESET_CYCLES - 1);
  localparam logic [TW-1:0] READY_LAST = TW'(p_READY_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(p_LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DB_FULL    = DW'(p_DEBOUNCE_CYCLES);
  localparam logic [3:0]    RETRY_MAX  = 4'(p_MAX_RETRIES);

  // Synchronizer lane order: {lock, rx_ready, tx_ready, prsnt_n, tx_fault, los}; prsnt_n resets to absent.
  localparam logic [5:0] SYNC_RST = 6'b000100;

  typedef enum logic [2:0] {
    ABSENT     = 3'd0,
    TX_OFF     = 3'd1,
    WAIT_READY = 3'd2,
    WAIT_LOCK  = 3'd3,
    LINK_UP    = 3'd4,
    RETRY      = 3'd5,
    FAILED     = 3'd6
  } state_t;

  logic [5:0]    sync_a, sync_b;
  logic          los_s, fault_s, prsnt_n_s, tx_ready_s, rx_ready_s, lock_s;
  logic          prsnt_prev, present_db;
  logic [DW-1:0] db_cnt, db_next;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    retry_q, retry_d;
  logic          active_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_a <= SYNC_RST;
      sync_b <= SYNC_RST;
    end else begin
      sync_a <= {i_rx_block_lock, i_rx_ready, i_tx_ready,
                 i_sfp_mod0_prsnt_n, i_sfp_tx_fault, i_sfp_los};
      sync_b <= sync_a;
    end
  end

  assign los_s      = sync_b[0];
  assign fault_s    = sync_b[1];
  assign prsnt_n_s  = sync_b[2];
  assign tx_ready_s = sync_b[3];
  assign rx_ready_s = sync_b[4];
  assign lock_s     = sync_b[5];

  // db_next is the number of consecutive cycles the synchronized level has held, including this one.
  always_comb begin
    if (prsnt_n_s != prsnt_prev)
      db_next = DW'(1);
    else if (db_cnt == DB_FULL)
      db_next = db_cnt;
    else
      db_next = db_cnt + 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prsnt_prev <= 1'b1;
      db_cnt     <= '0;
      present_db <= 1'b0;
    end else begin
      prsnt_prev <= prsnt_n_s;
      db_cnt     <= db_next;
      if (db_next == DB_FULL)
        present_db <= ~prsnt_n_s;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ABSENT:     if (present_db) state_d = TX_OFF;
      TX_OFF:     if (timer_q >= RESET_LAST) state_d = WAIT_READY;
      WAIT_READY: begin
        if (fault_s)                        state_d = RETRY;
        else if (tx_ready_s && rx_ready_s)  state_d = WAIT_LOCK;
        else if (timer_q >= READY_LAST)     state_d = RETRY;
      end
      WAIT_LOCK: begin
        if (fault_s)                             state_d = RETRY;
        else if (lock_s && !los_s)               state_d = LINK_UP;
        else if (!los_s && timer_q >= LOCK_LAST) state_d = RETRY;
      end
      LINK_UP: begin
        if (fault_s)                                              state_d = RETRY;
        else if (!lock_s || los_s || !tx_ready_s || !rx_ready_s) state_d = TX_OFF;
      end
      RETRY:      state_d = (retry_q >= RETRY_MAX) ? FAILED : TX_OFF;
      FAILED:     state_d = FAILED;
      default:    state_d = ABSENT;
    endcase
    if (!present_db && state_q != ABSENT)
      state_d = ABSENT;
  end

  // Retry count is bumped on entry to RETRY so the RETRY cycle already sees the new count.
  always_comb begin
    timer_d = timer_q;
    retry_d = retry_q;
    if (state_d != state_q)
      timer_d = '0;
    else if (!(state_q == WAIT_LOCK && los_s) && timer_q != '1)
      timer_d = timer_q + 1'b1;

    if (state_d == ABSENT)
      retry_d = '0;
    else if (state_d == LINK_UP && state_q != LINK_UP)
      retry_d = '0;
    else if (state_d == RETRY && state_q != RETRY && retry_q < RETRY_MAX)
      retry_d = retry_q + 4'd1;

    active_d = (state_d == WAIT_READY) || (state_d == WAIT_LOCK) || (state_d == LINK_UP);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q          <= ABSENT;
      timer_q          <= '0;
      retry_q          <= '0;
      o_sfp_tx_disable <= 1'b1;
      o_phy_reset      <= 1'b1;
      o_link_up        <= 1'b0;
      o_fault          <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      retry_q          <= retry_d;
      o_sfp_tx_disable <= ~active_d;
      o_phy_reset      <= ~active_d;
      o_link_up        <= (state_d == LINK_UP);
      o_fault          <= (state_d == FAILED);
    end
  end

  assign o_state       = state_q;
  assign o_retry_count = retry_q;

endmodule

// File: tb/tb_sfp_link_sequencer.sv
// Self-checking bench for sfp_link_sequencer: randomized delays, expected latencies and counts
// derived from the sequencer's timing rules.
module tb_sfp_link_sequencer;

  localparam int DEB = 8, RST = 4, RTO = 32, LTO = 32, MAXR = 2;
  localparam int SYNC = 2;
  localparam int INS_LAT = SYNC + DEB + 1;
  localparam int PIN_LAT = SYNC + 1;
  localparam int S_ABSENT = 0, S_TX_OFF = 1, S_WAIT_READY = 2, S_WAIT_LOCK = 3;
  localparam int S_LINK_UP = 4, S_RETRY = 5, S_FAILED = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       los = 1'b0, tx_fault = 1'b0, prsnt_n = 1'b1;
  logic       tx_ready = 1'b0, rx_ready = 1'b0, lock = 1'b0;
  logic       tx_disable, phy_reset, link_up, fault;
  logic [2:0] state;
  logic [3:0] retry_count;

  int compares = 0;
  int errors   = 0;
  int exp_retry = 0;

  sfp_link_sequencer #(
    .p_DEBOUNCE_CYCLES(DEB),
    .p_RESET_CYCLES(RST),
    .p_READY_TIMEOUT(RTO),
    .p_LOCK_TIMEOUT(LTO),
    .p_MAX_RETRIES(MAXR)
  ) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
    .i_sfp_los(los),
    .i_sfp_tx_fault(tx_fault),
    .i_sfp_mod0_prsnt_n(prsnt_n),
    .i_tx_ready(tx_ready),
    .i_rx_ready(rx_ready),
    .i_rx_block_lock(lock),
    .o_sfp_tx_disable(tx_disable),
    .o_phy_reset(phy_reset),
    .o_link_up(link_up),
    .o_fault(fault),
    .o_state(state),
    .o_retry_count(retry_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Returns the number of rising edges until o_state == s, or -1 if the budget expires.
  task automatic wait_state(input int s, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (int'(state) == s) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step(3);
    compares++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state); end
    compares++; if (tx_disable !== 1'b1) begin errors++; $display("FAIL rst_txdis: got %b want 1", tx_disable); end
    compares++; if (phy_reset !== 1'b1) begin errors++; $display("FAIL rst_phy: got %b want 1", phy_reset); end
    compares++; if (link_up !== 1'b0) begin errors++; $display("FAIL rst_link: got %b want 0", link_up); end
    compares++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b want 0", fault); end
    compares++; if (retry_count !== 4'd0) begin errors++; $display("FAIL rst_retry: got %0d want 0", retry_count); end
    rst_n = 1'b1;
    step(4);
    compares++; if (state !== 3'd0) begin errors++; $display("FAIL post_rst_state: got %0d want 0", state); end
  endtask

  task automatic test_glitch();
    int lo, hi;
    for (int p = 0; p < 12; p++) begin
      lo = (p < 4) ? 5 : $urandom_range(1, DEB - 1);
      hi = (p < 4) ? 2 : $urandom_range(1, 3);
      prsnt_n = 1'b0;
      for (int c = 0; c < lo; c++) begin
        step(1);
        compares++;
        if ({state, tx_disable} !== 4'b0001) begin
          errors++; $display("FAIL glitch_lo: got state %0d txdis %b want 0/1", state, tx_disable);
        end
      end
      prsnt_n = 1'b1;
      for (int c = 0; c < hi; c++) begin
        step(1);
        compares++;
        if ({state, tx_disable} !== 4'b0001) begin
          errors++; $display("FAIL glitch_hi: got state %0d txdis %b want 0/1", state, tx_disable);
        end
      end
    end
    step(DEB + 4);
    compares++; if (state !== 3'd0) begin errors++; $display("FAIL glitch_end: got %0d want 0", state); end
  endtask

  task automatic test_bringup();
    int n, rd, k, ld;
    tx_ready = 1'b0; rx_ready = 1'b0; lock = 1'b0; los = 1'b0; tx_fault = 1'b0;
    prsnt_n = 1'b0;
    wait_state(S_TX_OFF, 64, n);
    compares++; if (n !== INS_LAT) begin errors++; $display("FAIL ins_lat: got %0d want %0d", n, INS_LAT); end
    compares++; if ({tx_disable, phy_reset} !== 2'b11) begin errors++; $display("FAIL txoff_out: got %b%b want 11", tx_disable, phy_reset); end
    wait_state(S_WAIT_READY, 64, n);
    compares++; if (n !== RST) begin errors++; $display("FAIL txoff_dwell: got %0d want %0d", n, RST); end
    compares++; if ({tx_disable, phy_reset} !== 2'b00) begin errors++; $display("FAIL wready_out: got %b%b want 00", tx_disable, phy_reset); end
    rd = $urandom_range(3, 15);
    k  = $urandom_range(0, 5);
    step(rd);
    tx_ready = 1'b1;
    step(k);
    rx_ready = 1'b1;
    wait_state(S_WAIT_LOCK, 40, n);
    compares++; if (n !== PIN_LAT) begin errors++; $display("FAIL ready_lat: got %0d want %0d", n, PIN_LAT); end
    ld = $urandom_range(3, 20);
    step(ld);
    lock = 1'b1;
    wait_state(S_LINK_UP, 40, n);
    exp_retry = 0;
    compares++; if (n !== PIN_LAT) begin errors++; $display("FAIL lock_lat: got %0d want %0d", n, PIN_LAT); end
    compares++; if (link_up !== 1'b1) begin errors++; $display("FAIL link_up: got %b want 1", link_up); end
    compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL up_retry: got %0d want %0d", retry_count, exp_retry); end
  endtask

  task automatic test_tx_fault();
    int n;
    tx_fault = 1'b1;
    step(1);
    tx_fault = 1'b0;
    wait_state(S_RETRY, 16, n);
    exp_retry = (exp_retry + 1 > MAXR) ? MAXR : exp_retry + 1;
    compares++; if (n !== PIN_LAT - 1) begin errors++; $display("FAIL fault_lat: got %0d want %0d", n, PIN_LAT - 1); end
    compares++; if (link_up !== 1'b0) begin errors++; $display("FAIL fault_linkdrop: got %b want 0", link_up); end
    compares++; if ({tx_disable, phy_reset} !== 2'b11) begin errors++; $display("FAIL retry_out: got %b%b want 11", tx_disable, phy_reset); end
    compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL fault_retry: got %0d want %0d", retry_count, exp_retry); end
    wait_state(S_TX_OFF, 8, n);
    compares++; if (n !== 1) begin errors++; $display("FAIL retry_len: got %0d want 1", n); end
    compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL txoff_retry: got %0d want %0d", retry_count, exp_retry); end
    wait_state(S_LINK_UP, 64, n);
    exp_retry = 0;
    compares++; if (n !== RST + 2) begin errors++; $display("FAIL relink_lat: got %0d want %0d", n, RST + 2); end
    compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL relink_retry: got %0d want %0d", retry_count, exp_retry); end
  endtask

  task automatic test_lock_loss();
    int n, d;
    lock = 1'b0;
    wait_state(S_TX_OFF, 16, n);
    compares++; if (n !== PIN_LAT) begin errors++; $display("FAIL lockloss_lat: got %0d want %0d", n, PIN_LAT); end
    compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL lockloss_retry: got %0d want %0d", retry_count, exp_retry); end
    compares++; if (link_up !== 1'b0) begin errors++; $display("FAIL lockloss_link: got %b want 0", link_up); end
    d = $urandom_range(0, RST - 1);
    step(d);
    prsnt_n = 1'b1;
    wait_state(S_ABSENT, 32, n);
    exp_retry = 0;
    compares++; if (n !== INS_LAT) begin errors++; $display("FAIL removal_lat: got %0d want %0d", n, INS_LAT); end
    compares++; if ({tx_disable, phy_reset} !== 2'b11) begin errors++; $display("FAIL removal_out: got %b%b want 11", tx_disable, phy_reset); end
  endtask

  task automatic test_timeout_failed();
    int n;
    tx_ready = 1'($urandom_range(0, 1));
    rx_ready = 1'b0;
    lock = 1'b0;
    prsnt_n = 1'b0;
    wait_state(S_TX_OFF, 64, n);
    compares++; if (n !== INS_LAT) begin errors++; $display("FAIL to_ins: got %0d want %0d", n, INS_LAT); end
    for (int a = 1; a <= MAXR; a++) begin
      wait_state(S_WAIT_READY, 16, n);
      compares++; if (n !== RST) begin errors++; $display("FAIL to_dwell: got %0d want %0d", n, RST); end
      wait_state(S_RETRY, 64, n);
      exp_retry = (exp_retry + 1 > MAXR) ? MAXR : exp_retry + 1;
      compares++; if (n !== RTO) begin errors++; $display("FAIL ready_timeout: got %0d want %0d", n, RTO); end
      compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL to_retry: got %0d want %0d", retry_count, exp_retry); end
      wait_state((exp_retry == MAXR) ? S_FAILED : S_TX_OFF, 8, n);
      compares++; if (n !== 1) begin errors++; $display("FAIL to_after_retry: got %0d want 1", n); end
    end
    compares++; if (state !== 3'd6) begin errors++; $display("FAIL failed_state: got %0d want 6", state); end
    compares++; if ({fault, tx_disable, phy_reset, link_up} !== 4'b1110) begin errors++; $display("FAIL failed_out: got %b%b%b%b want 1110", fault, tx_disable, phy_reset, link_up); end
    compares++; if (int'(retry_count) !== MAXR) begin errors++; $display("FAIL failed_retry: got %0d want %0d", retry_count, MAXR); end
    tx_ready = 1'b1; rx_ready = 1'b1; lock = 1'b1;
    step($urandom_range(20, 60));
    compares++; if ({state, fault} !== 4'b1101) begin errors++; $display("FAIL failed_sticky: got %0d/%b want 6/1", state, fault); end
    prsnt_n = 1'b1;
    wait_state(S_ABSENT, 32, n);
    exp_retry = 0;
    compares++; if (n !== INS_LAT) begin errors++; $display("FAIL failed_removal: got %0d want %0d", n, INS_LAT); end
    compares++; if ({fault, retry_count} !== 5'd0) begin errors++; $display("FAIL absent_clear: got %b/%0d want 0/0", fault, retry_count); end
  endtask

  task automatic test_los_lock();
    int n, h;
    lock = 1'b0;
    prsnt_n = 1'b0;
    wait_state(S_TX_OFF, 64, n);
    compares++; if (n !== INS_LAT) begin errors++; $display("FAIL reins_lat: got %0d want %0d", n, INS_LAT); end
    wait_state(S_WAIT_LOCK, 16, n);
    compares++; if (n !== RST + 1) begin errors++; $display("FAIL reins_wlock: got %0d want %0d", n, RST + 1); end
    los = 1'b1;
    h = $urandom_range(90, 120);
    for (int c = 0; c < h; c++) begin
      lock = 1'($urandom_range(0, 1));
      step(1);
    end
    compares++; if (state !== 3'd3) begin errors++; $display("FAIL los_hold: got %0d want 3", state); end
    los = 1'b0;
    lock = 1'b1;
    wait_state(S_LINK_UP, 16, n);
    compares++; if (n !== PIN_LAT) begin errors++; $display("FAIL los_release: got %0d want %0d", n, PIN_LAT); end
    los = 1'b1;
    wait_state(S_TX_OFF, 16, n);
    compares++; if (n !== PIN_LAT) begin errors++; $display("FAIL los_linkdown: got %0d want %0d", n, PIN_LAT); end
    compares++; if (int'(retry_count) !== exp_retry) begin errors++; $display("FAIL los_retry: got %0d want %0d", retry_count, exp_retry); end
    wait_state(S_WAIT_LOCK, 16, n);
    compares++; if (n !== RST + 1) begin errors++; $display("FAIL los_wlock: got %0d want %0d", n, RST + 1); end
  endtask

  task automatic test_reset_mid();
    int n;
    step($urandom_range(1, 10));
    #2;
    rst_n = 1'b0;
    #1;
    compares++; if ({state, retry_count} !== 7'd0) begin errors++; $display("FAIL midrst_state: got %0d/%0d want 0/0", state, retry_count); end
    compares++; if ({tx_disable, phy_reset, link_up, fault} !== 4'b1100) begin errors++; $display("FAIL midrst_out: got %b%b%b%b want 1100", tx_disable, phy_reset, link_up, fault); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_state(S_TX_OFF, 64, n);
    compares++; if (n !== INS_LAT) begin errors++; $display("FAIL midrst_reins: got %0d want %0d", n, INS_LAT); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bringup();
    test_tx_fault();
    test_lock_loss();
    test_timeout_failed();
    test_los_lock();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
